// File: rtl/regfile_debug_port.sv
// regfile_debug_port: debug initiator on the RegisterFile ports.
// Dumps x0..NUM_REGS-1 as a ready/valid word stream, or loads x1..NUM_REGS-1
// from a ready/valid word stream (x0 is never written).
// Optional feature macro: REGDBG_CHECKSUM_EN -- appends an XOR checksum word
// to dumps, expects one after loads, and adds the sticky out_CsumErr port.
module regfile_debug_port #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_Start,
  input  logic              in_Mode,
  output logic [ADDR_W-1:0] out_ReadReg,
  input  logic [DATA_W-1:0] in_ReadData,
  output logic              out_RegWrite,
  output logic [ADDR_W-1:0] out_WriteAddr,
  output logic [DATA_W-1:0] out_WriteData,
  output logic              out_DumpValid,
  input  logic              in_DumpReady,
  output logic [DATA_W-1:0] out_DumpData,
  input  logic              in_LoadValid,
  output logic              out_LoadReady,
  input  logic [DATA_W-1:0] in_LoadData,
  output logic              out_Busy,
  output logic              out_Done
`ifdef REGDBG_CHECKSUM_EN
  ,output logic             out_CsumErr
`endif
);

`ifdef REGDBG_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // One extra count value so the checksum slot (index NUM_REGS) is representable.
  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] CSUM_IDX = CNT_W'(NUM_REGS);
  localparam logic [CNT_W-1:0] LOAD_MAX = CSUM_EN ? CSUM_IDX : LAST;

  typedef enum logic [2:0] {IDLE, DUMP_RD, DUMP_WAIT, LOAD, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic              dump_hs, load_hs;

  assign dump_hs = (state == DUMP_WAIT) && out_DumpValid && in_DumpReady;
  assign load_hs = in_LoadValid && out_LoadReady;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    out_Busy      = (state != IDLE);
    out_Done      = (state == DONE);
    out_ReadReg   = '0;
    out_LoadReady = 1'b0;
    case (state)
      IDLE: begin
        if (in_Start) state_nxt = in_Mode ? LOAD : DUMP_RD;
      end
      DUMP_RD: begin
        out_ReadReg = cnt[ADDR_W-1:0];
        state_nxt   = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        out_ReadReg = cnt[ADDR_W-1:0];
        if (dump_hs) begin
          if (cnt == LAST)          state_nxt = CSUM_EN ? DUMP_WAIT : DONE;
          else if (cnt == CSUM_IDX) state_nxt = DONE;
          else                      state_nxt = DUMP_RD;
        end
      end
      LOAD: begin
        // No accept in the write-issue cycle, so at most one word per 2 cycles.
        out_LoadReady = !out_RegWrite && (cnt <= LOAD_MAX);
        // Without checksum, finish once the final register write has gone out.
        if (!CSUM_EN && out_RegWrite && cnt == CSUM_IDX) state_nxt = DONE;
        if (CSUM_EN && load_hs && cnt == CSUM_IDX)       state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: counter, dump word register, write port and running XOR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt           <= '0;
      acc           <= '0;
      out_DumpData  <= '0;
      out_DumpValid <= 1'b0;
      out_RegWrite  <= 1'b0;
      out_WriteAddr <= '0;
      out_WriteData <= '0;
    end else begin
      out_RegWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (in_Start) begin
            cnt <= in_Mode ? CNT_W'(1) : '0;
            acc <= '0;
          end
        end
        DUMP_RD: begin
          out_DumpData  <= in_ReadData;
          out_DumpValid <= 1'b1;
          acc           <= acc ^ in_ReadData;
        end
        DUMP_WAIT: begin
          if (dump_hs) begin
            if (CSUM_EN && cnt == LAST) begin
              // Checksum word follows directly, same handshake, valid stays up.
              out_DumpData <= acc;
              cnt          <= CSUM_IDX;
            end else begin
              out_DumpValid <= 1'b0;
              cnt <= (cnt == LAST || cnt == CSUM_IDX) ? '0 : cnt + CNT_W'(1);
            end
          end
        end
        LOAD: begin
          if (load_hs) begin
            if (cnt == CSUM_IDX) begin
              cnt <= '0;
            end else begin
              out_RegWrite  <= 1'b1;
              out_WriteAddr <= cnt[ADDR_W-1:0];
              out_WriteData <= in_LoadData;
              acc           <= acc ^ in_LoadData;
              cnt           <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

`ifdef REGDBG_CHECKSUM_EN
  // Sticky checksum error: cleared by reset or a new start, set on a bad load checksum.
  always_ff @(posedge CLK) begin
    if (RST)
      out_CsumErr <= 1'b0;
    else if (state == IDLE && in_Start)
      out_CsumErr <= 1'b0;
    else if (state == LOAD && load_hs && cnt == CSUM_IDX && in_LoadData != acc)
      out_CsumErr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: a behavioural RegisterFile is attached, a
// reference array of expected register contents predicts every dump stream.
`timescale 1ns/1ps
module tb_regfile_debug_port;
  logic        CLK = 0, RST = 1;
  logic        in_Start = 0, in_Mode = 0;
  logic [3:0]  out_ReadReg;
  logic [15:0] in_ReadData;
  logic        out_RegWrite;
  logic [3:0]  out_WriteAddr;
  logic [15:0] out_WriteData;
  logic        out_DumpValid;
  logic        in_DumpReady = 0;
  logic [15:0] out_DumpData;
  logic        in_LoadValid = 0;
  logic        out_LoadReady;
  logic [15:0] in_LoadData = 0;
  logic        out_Busy, out_Done;
`ifdef REGDBG_CHECKSUM_EN
  logic        csum_err;
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  int n_checks = 0, n_pass = 0, n_fail = 0;

  regfile_debug_port dut (
    .CLK(CLK), .RST(RST), .in_Start(in_Start), .in_Mode(in_Mode),
    .out_ReadReg(out_ReadReg), .in_ReadData(in_ReadData),
    .out_RegWrite(out_RegWrite), .out_WriteAddr(out_WriteAddr), .out_WriteData(out_WriteData),
    .out_DumpValid(out_DumpValid), .in_DumpReady(in_DumpReady), .out_DumpData(out_DumpData),
    .in_LoadValid(in_LoadValid), .out_LoadReady(out_LoadReady), .in_LoadData(in_LoadData),
    .out_Busy(out_Busy), .out_Done(out_Done)
`ifdef REGDBG_CHECKSUM_EN
    , .out_CsumErr(csum_err)
`endif
  );

  always #5 CLK = ~CLK;

  // Behavioural RegisterFile with a backdoor preload port.
  logic        bd_we = 0;
  logic [3:0]  bd_addr = 0;
  logic [15:0] bd_data = 0;
  logic [15:0] rf [16];
  always @(posedge CLK) begin
    if (bd_we)             rf[bd_addr] <= bd_data;
    else if (out_RegWrite) rf[out_WriteAddr] <= out_WriteData;
  end
  assign in_ReadData = rf[out_ReadReg];

  // Reference model state.
  logic [15:0] ref_regs [16];
  logic [15:0] ld_words [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  out_Busy, 0);
    check({tag, "_done"},  out_Done, 0);
    check({tag, "_dv"},    out_DumpValid, 0);
    check({tag, "_dd"},    out_DumpData, 0);
    check({tag, "_rw"},    out_RegWrite, 0);
    check({tag, "_wa"},    out_WriteAddr, 0);
    check({tag, "_wd"},    out_WriteData, 0);
    check({tag, "_lr"},    out_LoadReady, 0);
    check({tag, "_rr"},    out_ReadReg, 0);
  endtask

  // Dump with optional stall on one word, random ready, stray start, or reset at a word.
  task automatic do_dump(input int stall_word, input bit rnd, input bit mid_start, input int rst_word);
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] x, held_data;
    int dones, stall_cnt;
    bit held, r, aborted;
    x = 0; dones = 0; stall_cnt = 0; held = 0; aborted = 0; held_data = 0;
    for (int i = 0; i < 16; i++) begin exp_q.push_back(ref_regs[i]); x ^= ref_regs[i]; end
    if (CSUM) exp_q.push_back(x);
    @(negedge CLK); in_Start = 1; in_Mode = 0;
    @(negedge CLK); in_Start = 0;
    check("dump_busy", out_Busy, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (held) begin
        check("stall_valid", out_DumpValid, 1);
        check("stall_data", out_DumpData, held_data);
      end
      if (out_Done) begin dones++; break; end
      if (out_DumpValid && got_q.size() == rst_word) begin
        in_DumpReady = 0; in_Start = 0; RST = 1;
        @(negedge CLK); RST = 0;
        aborted = 1;
        break;
      end
      r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_DumpValid && got_q.size() == stall_word && stall_cnt < 5) begin r = 0; stall_cnt++; end
      in_DumpReady = r;
      in_Start = mid_start && got_q.size() == 5;
      in_Mode  = mid_start;
      held = out_DumpValid && !r;
      held_data = out_DumpData;
      if (out_DumpValid && r) got_q.push_back(out_DumpData);
      @(negedge CLK);
    end
    in_DumpReady = 0; in_Start = 0; in_Mode = 0;
    if (aborted) begin
      check_idle_zero("rst_mid");
      check("rst_words", got_q.size(), rst_word);
      return;
    end
    check("dump_done_pulse", dones, 1);
    check("dump_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("dump_word%0d", i), got_q[i], exp_q[i]);
    @(negedge CLK);
    check("dump_done_1cyc", out_Done, 0);
    check("dump_idle", out_Busy, 0);
  endtask

  // Load ld_words[1..15] (plus checksum word when enabled, optionally corrupted).
  task automatic do_load(input bit rnd, input bit bad_csum);
    logic [15:0] x;
    int idx, wcnt, dones, last;
    x = 0; idx = 1; wcnt = 0; dones = 0;
    last = CSUM ? 16 : 15;
    for (int i = 1; i < 16; i++) x ^= ld_words[i];
    @(negedge CLK); in_Start = 1; in_Mode = 1;
    @(negedge CLK); in_Start = 0; in_Mode = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (out_Done) begin dones++; break; end
      if (out_RegWrite) begin
        wcnt++;
        check("wr_addr", out_WriteAddr, wcnt[3:0]);
        check("wr_data", out_WriteData, ld_words[wcnt[3:0]]);
        check("wr_ready_low", out_LoadReady, 0);
      end
      if (idx <= last && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_LoadValid = 1;
        in_LoadData = (idx == 16) ? (x ^ {15'd0, bad_csum}) : ld_words[idx[3:0]];
        if (out_LoadReady) idx++;
      end else begin
        in_LoadValid = 0;
      end
      @(negedge CLK);
    end
    in_LoadValid = 0;
    check("load_writes", wcnt, 15);
    check("load_done_pulse", dones, 1);
    check("load_accepts", idx, last + 1);
    for (int i = 1; i < 16; i++) ref_regs[i] = ld_words[i];
`ifdef REGDBG_CHECKSUM_EN
    check("csum_err", csum_err, bad_csum);
`endif
    @(negedge CLK);
    check("load_idle", out_Busy, 0);
  endtask

  initial begin
    // Preload x1=1, x2=0x8001, rest 0 while reset is held.
    for (int i = 0; i < 16; i++) begin
      ref_regs[i] = (i == 1) ? 16'h0001 : (i == 2) ? 16'h8001 : 16'h0000;
      @(negedge CLK);
      bd_we = 1; bd_addr = i[3:0]; bd_data = ref_regs[i];
    end
    @(negedge CLK); bd_we = 0;
    check_idle_zero("reset");
`ifdef REGDBG_CHECKSUM_EN
    check("reset_csum_err", csum_err, 0);
`endif
    RST = 0;

    do_dump(-1, 0, 0, -1);                       // plain dump, ready always high
    do_dump(3, 1, 0, -1);                        // stall word 3 for 5 cycles
    for (int i = 0; i < 16; i++) ld_words[i] = 16'h1000 + i[15:0];
    do_load(0, 0);                               // load 0x1000+i
    do_dump(-1, 1, 0, -1);                       // x0=0, xi=0x1000+i (+checksum)
    do_dump(-1, 1, 1, -1);                       // stray start mid-dump ignored
    do_dump(-1, 0, 0, 7);                        // reset at word 7
    do_dump(-1, 0, 0, -1);                       // fresh dump from x0
    for (int i = 0; i < 16; i++) ld_words[i] = 16'($urandom);
    do_load(1, CSUM);                            // random words, bad checksum when enabled
    do_dump(-1, 1, 0, -1);
    do_load(1, 0);                               // start clears sticky error
    do_dump(-1, 1, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
